// File: rtl/ship_figure_server_if.sv
// Figure/board interface between the drawer + game logic (master) and the
// ship_figure_server responder (slave).
// Optional macro SHIP_HIDE_EN adds the hide_ships input used for the
// opponent's board.
interface ship_figure_server_if;
    logic [5:0]  figure_xy;
    logic [4:0]  figure_line;
    logic [63:0] figure_pixels;
    logic        cell_wr_valid;
    logic        cell_wr_ready;
    logic [5:0]  cell_wr_addr;
    logic [1:0]  cell_wr_state;
    logic        clear_req;
    logic        busy;

`ifdef SHIP_HIDE_EN
    logic        hide_ships;

    modport master (
        output figure_xy, figure_line, cell_wr_valid, cell_wr_addr,
               cell_wr_state, clear_req, hide_ships,
        input  figure_pixels, cell_wr_ready, busy
    );

    modport slave (
        input  figure_xy, figure_line, cell_wr_valid, cell_wr_addr,
               cell_wr_state, clear_req, hide_ships,
        output figure_pixels, cell_wr_ready, busy
    );
`else
    modport master (
        output figure_xy, figure_line, cell_wr_valid, cell_wr_addr,
               cell_wr_state, clear_req,
        input  figure_pixels, cell_wr_ready, busy
    );

    modport slave (
        input  figure_xy, figure_line, cell_wr_valid, cell_wr_addr,
               cell_wr_state, clear_req,
        output figure_pixels, cell_wr_ready, busy
    );
`endif
endinterface

// File: rtl/ship_figure_server.sv
// ship_figure_server: holds the 8x8 battleship board (2 bits per cell) and
// serves one 32-pixel, 2-bpp sprite line per cycle through a 2-stage read
// pipeline. Game logic writes cells via a valid/ready port; a clear FSM
// sweeps all 64 cells back to EMPTY on request.
// Optional macro SHIP_HIDE_EN: adds hide_ships; when high, SHIP cells render
// as EMPTY while HIT and MISS render normally.
module ship_figure_server #(
    parameter int SHIP_MARGIN = 4,
    parameter int MISS_LO     = 12,
    parameter int MISS_HI     = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    ship_figure_server_if.slave   bus
);

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_SHIP  = 2'd1,
        CELL_HIT   = 2'd2,
        CELL_MISS  = 2'd3
    } cell_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } fsm_t;

    // Builds a sprite line with 'code' on pixels lo..hi and 00 elsewhere.
    function automatic logic [63:0] span_line(int lo, int hi, logic [1:0] code);
        logic [63:0] line_bits;
        line_bits = '0;
        for (int p = 0; p < 32; p++) begin
            if (p >= lo && p <= hi) line_bits[63-2*p -: 2] = code;
        end
        return line_bits;
    endfunction

    localparam logic [63:0] BODY_LINE  = span_line(SHIP_MARGIN, 31 - SHIP_MARGIN, 2'b01);
    localparam logic [63:0] MISS_LINE  = span_line(MISS_LO, MISS_HI, 2'b10);
    localparam logic [4:0]  BODY_FIRST = 5'(SHIP_MARGIN);
    localparam logic [4:0]  BODY_LAST  = 5'(31 - SHIP_MARGIN);
    localparam logic [4:0]  MISS_FIRST = 5'(MISS_LO);
    localparam logic [4:0]  MISS_LAST  = 5'(MISS_HI);

    cell_t       board [64];
    cell_t       cell_state_q;
    fsm_t        state;
    logic [5:0]  sweep;
    logic        busy_q;
    logic        ready_q;
    logic [63:0] pixels_q;
    logic [63:0] sprite_next;
    logic [63:0] hit_diag;
    logic        body_row;
    logic        miss_row;
    logic        hide;

`ifdef SHIP_HIDE_EN
    assign hide = bus.hide_ships;
`else
    assign hide = 1'b0;
`endif

    assign body_row = (bus.figure_line >= BODY_FIRST) && (bus.figure_line <= BODY_LAST);
    assign miss_row = (bus.figure_line >= MISS_FIRST) && (bus.figure_line <= MISS_LAST);

    // Stage-2 sprite selection from the latched cell state and the current line.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        sprite_next = '0;
        // Diagonals: pixel l sits at bits [63-2l:62-2l], pixel 31-l at [2l+1:2l].
        hit_diag = (64'h3 << (6'd62 - {bus.figure_line, 1'b0}))
                 | (64'h3 << {bus.figure_line, 1'b0});
        case (cell_state_q)
            CELL_SHIP: if (body_row && !hide) sprite_next = BODY_LINE;
            // Both diagonal pixels of a body row fall inside the body columns.
            CELL_HIT:  if (body_row) sprite_next = BODY_LINE | hit_diag;
            CELL_MISS: if (miss_row) sprite_next = MISS_LINE;
            default:   sprite_next = '0;
        endcase
    end

    // Read pipeline: stage 1 looks up the cell, stage 2 registers the sprite line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_state_q <= CELL_EMPTY;
            pixels_q     <= '0;
        end else begin
            // NOTE: non-blocking assignment samples board before this edge's
            // write lands, so a same-cycle write/read returns the old value.
            cell_state_q <= board[bus.figure_xy];
            pixels_q     <= sprite_next;
        end
    end

    // Board storage, write port and clear-sweep FSM with registered busy/ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the board is a small flop array, so it is reset directly;
            // this is what lets a mid-sweep reset leave every cell EMPTY.
            for (int i = 0; i < 64; i++) board[i] <= CELL_EMPTY;
            state   <= IDLE;
            sweep   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cell_wr_valid && ready_q)
                        board[bus.cell_wr_addr] <= cell_t'(bus.cell_wr_state);
                    if (bus.clear_req) begin
                        state   <= CLEAR;
                        sweep   <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clear_req is ignored here; the sweep is never restarted.
                    board[sweep] <= CELL_EMPTY;
                    sweep        <= sweep + 6'd1;
                    if (sweep == 6'd63) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.figure_pixels = pixels_q;
    assign bus.busy          = busy_q;
    assign bus.cell_wr_ready = ready_q;

endmodule

// File: tb/tb_ship_figure_server.sv
// Self-checking bench for ship_figure_server: a driver issues one read per
// cycle plus writes/clears, predicts responses from a behavioural board model
// and pushes them to a scoreboard; a monitor pops and compares on the cycle
// each response is due. Build with +define+SHIP_HIDE_EN to cover hide_ships.
module tb_ship_figure_server;
    localparam int M   = 4;
    localparam int MLO = 12;
    localparam int MHI = 19;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ship_figure_server_if bus();

    ship_figure_server #(
        .SHIP_MARGIN(M),
        .MISS_LO(MLO),
        .MISS_HI(MHI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          xy;
        int          line;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference board and control model.
    int model_board [64];
    bit model_busy;
    bit model_ready;
    int model_sweep;
    int pend_line;
    bit pend_hide;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // 2-bit pixel code for cell state s at pixel p, line l.
    function automatic int pixel_code(int s, int p, int l, bit hide);
        bit body;
        body = (p >= M) && (p <= 31 - M) && (l >= M) && (l <= 31 - M);
        case (s)
            1: return (body && !hide) ? 1 : 0;
            2: begin
                if (body && (p == l || p == 31 - l)) return 3;
                return body ? 1 : 0;
            end
            3: return (p >= MLO && p <= MHI && l >= MLO && l <= MHI) ? 2 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] sprite_model(int s, int l, bit hide);
        logic [63:0] r;
        r = '0;
        for (int p = 0; p < 32; p++) r[63-2*p -: 2] = 2'(pixel_code(s, p, l, hide));
        return r;
    endfunction

    // One cycle, called at a falling edge: check control outputs, drive the
    // next edge's inputs, predict the read, then advance the model by one edge.
    task automatic step(input int xy, input int line, input bit wv, input int wa,
                        input int ws, input bit clr, input bit hide, input bit push,
                        input bit use_golden, input logic [63:0] golden);
        exp_t e;
        bit   hide_eff;
`ifdef SHIP_HIDE_EN
        hide_eff = hide;
`else
        hide_eff = 1'b0;
`endif
        check("busy", {63'd0, bus.busy}, {63'd0, model_busy});
        check("ready", {63'd0, bus.cell_wr_ready}, {63'd0, model_ready});

        bus.figure_xy     = 6'(xy);
        bus.figure_line   = 5'(pend_line);
`ifdef SHIP_HIDE_EN
        bus.hide_ships    = pend_hide;
`endif
        pend_line         = line;
        pend_hide         = hide_eff;
        bus.cell_wr_valid = wv;
        bus.cell_wr_addr  = 6'(wa);
        bus.cell_wr_state = 2'(ws);
        bus.clear_req     = clr;

        if (push) begin
            e.due  = cyc + 2;
            e.xy   = xy;
            e.line = line;
            e.exp  = use_golden ? golden : sprite_model(model_board[xy], line, hide_eff);
            sb.push_back(e);
        end

        if (model_busy) begin
            model_board[model_sweep] = 0;
            if (model_sweep == 63) begin
                model_busy  = 1'b0;
                model_ready = 1'b1;
            end else begin
                model_sweep++;
            end
        end else begin
            if (wv && model_ready) model_board[wa] = ws;
            if (clr) begin
                model_busy  = 1'b1;
                model_ready = 1'b0;
                model_sweep = 0;
            end else begin
                model_ready = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic rd(input int xy, input int line);
        step(xy, line, 0, 0, 0, 0, 0, 1, 0, '0);
    endtask

    task automatic rd_gold(input int xy, input int line, input bit hide, input logic [63:0] g);
        step(xy, line, 0, 0, 0, 0, hide, 1, 1, g);
    endtask

    task automatic wr(input int wa, input int ws);
        step($urandom_range(63), $urandom_range(31), 1, wa, ws, 0, 0, 1, 0, '0);
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        bus.cell_wr_valid = 1'b0;
        bus.clear_req     = 1'b0;
        #1;
        check("busy_in_reset", {63'd0, bus.busy}, 64'd0);
        check("ready_in_reset", {63'd0, bus.cell_wr_ready}, 64'd0);
        check("pixels_in_reset", bus.figure_pixels, 64'd0);
        sb.delete();
        for (int i = 0; i < 64; i++) model_board[i] = 0;
        model_busy  = 1'b0;
        model_ready = 1'b0;
        model_sweep = 0;
        pend_line   = 0;
        pend_hide   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares every response on the cycle it is due.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check($sformatf("pixels xy=%0d line=%0d", e.xy, e.line),
                      bus.figure_pixels, e.exp);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int busy_count;
        bus.figure_xy     = '0;
        bus.figure_line   = '0;
        bus.cell_wr_valid = 1'b0;
        bus.cell_wr_addr  = '0;
        bus.cell_wr_state = '0;
        bus.clear_req     = 1'b0;
`ifdef SHIP_HIDE_EN
        bus.hide_ships    = 1'b0;
`endif
        @(negedge clk);
        do_reset();

        // Empty board after reset.
        for (int i = 0; i < 64; i++) rd(i, $urandom_range(31));

        // Latency / SHIP sprite.
        wr(9, 1);
        rd_gold(9, 10, 0, 64'h0055_5555_5555_5500);
        rd_gold(9, 2, 0, 64'h0);

        // HIT and MISS sprites.
        wr(20, 2);
        wr(21, 3);
        rd_gold(20, 10, 0, 64'h0055_5D55_5575_5500);
        rd_gold(21, 15, 0, 64'h0000_00AA_AA00_0000);

        // Same-cycle write and read of cell 5.
        step(5, 15, 1, 5, 3, 0, 0, 1, 1, 64'h0);
        rd_gold(5, 15, 0, 64'h0000_00AA_AA00_0000);

        // Fill with SHIP, then clear with a same-cycle write, a blocked write
        // and a second clear_req during the sweep.
        for (int i = 0; i < 64; i++) wr(i, 1);
        step(3, 8, 1, 7, 2, 1, 0, 1, 0, '0);
        busy_count = 0;
        for (int k = 0; k < 70; k++) begin
            if (bus.busy) busy_count++;
            step($urandom_range(63), $urandom_range(31), (k == 10), 3, 1, (k == 20),
                 0, 1, 0, '0);
        end
        check("busy_length", 64'(busy_count), 64'd64);
        for (int i = 0; i < 64; i++) rd(i, $urandom_range(M, 31 - M));

        // Reset at sweep cycle 30.
        for (int i = 0; i < 64; i += 3) wr(i, $urandom_range(1, 3));
        step(0, 0, 0, 0, 0, 1, 0, 1, 0, '0);
        for (int k = 0; k < 30; k++) rd($urandom_range(63), $urandom_range(31));
        do_reset();
        for (int i = 0; i < 64; i++) rd(i, $urandom_range(M, 31 - M));

`ifdef SHIP_HIDE_EN
        // Hidden ships: SHIP blanks, HIT keeps its diagonal.
        wr(1, 1);
        wr(2, 2);
        rd_gold(1, 10, 1, 64'h0);
        rd_gold(2, 10, 1, 64'h0055_5D55_5575_5500);
        rd_gold(1, 10, 0, 64'h0055_5555_5555_5500);
`endif

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(63), $urandom_range(31), $urandom_range(1),
                 $urandom_range(63), $urandom_range(3), ($urandom_range(199) == 0),
                 $urandom_range(1), 1, 0, '0);
        end

        // Drain the pipeline.
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ship_figure_server.md
Name: ship_figure_server

Overview:
- Responder side of the ship-drawing figure interface.
- Holds the 8x8 game board state, one 2-bit state per cell, indexed by figure_xy.
- For each request (figure_xy, then figure_line one cycle later) it returns one 32-pixel, 2-bpp sprite line on figure_pixels.
- Game logic updates cells through a valid/ready write port. A clear FSM sweeps the board back to EMPTY on request.

Parameters:
- SHIP_MARGIN, default 4: inset, in pixels and lines, of the ship body within the 32x32 cell sprite.
- MISS_LO, default 12: first pixel/line of the miss marker square.
- MISS_HI, default 19: last pixel/line of the miss marker square.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- figure_xy  in  6  cell index (column + 8*row), sampled every clk.
- figure_line  in  5  sprite line within the cell, sampled every clk.
- figure_pixels  out  64  sprite line; pixel p occupies bits [63-2p : 62-2p].
- cell_wr_valid  in  1  write request.
- cell_wr_ready  out  1  write accepted when high together with valid.
- cell_wr_addr  in  6  cell to write.
- cell_wr_state  in  2  new state: 0 EMPTY, 1 SHIP, 2 HIT, 3 MISS.
- clear_req  in  1  single-cycle pulse that starts a board clear.
- busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset (async, rst=1):
  - All 64 cells become EMPTY.
  - figure_pixels=0, FSM=IDLE, busy=0, cell_wr_ready=0 while rst is held.
- Pixel codes: 00 transparent, 01 grey, 10 white, 11 black.
- Sprite definition (p = pixel 0..31, l = line 0..31, M = SHIP_MARGIN):
  - EMPTY: all 00.
  - SHIP: 01 where M <= p,l <= 31-M; else 00.
  - HIT: SHIP pattern, except 11 where p==l or p==31-l, inside the ship body only.
  - MISS: 10 where MISS_LO <= p,l <= MISS_HI; else 00.
- Read pipeline:
  - Stage 1: edge N latches cell_state_q = board[figure_xy].
  - Stage 2: edge N+1 latches figure_pixels = sprite(cell_state_q, figure_line).
  - Total latency: 2 clk from figure_xy, 1 clk from figure_line. This matches the drawer, which issues figure_line one cycle after figure_xy and consumes pixels two cycles after figure_xy.
  - Reads run every cycle, regardless of FSM state or write activity.
- Write port:
  - cell_wr_ready = 1 only in IDLE.
  - When valid && ready at an edge, board[cell_wr_addr] <= cell_wr_state.
  - One write per cycle; no back-pressure in IDLE.
  - A write and a stage-1 read of the same cell in the same cycle: the read returns the old value; the new value is visible from the next read.
- FSM states:
  - IDLE: clear_req=1 -> CLEAR, sweep counter = 0, busy = 1 from the next cycle.
  - CLEAR: writes board[counter] <= EMPTY and increments the counter each cycle. After writing cell 63 -> IDLE, busy drops on the same edge. Exactly 64 cycles.
- Boundary cases:
  - clear_req during CLEAR: ignored; the sweep is not restarted.
  - clear_req and an accepted write in the same IDLE cycle: the write lands, and the sweep later clears it to EMPTY.
  - Counter is 6 bits with a terminal compare at 63; no wrap into a second pass.
  - rst asserted mid-sweep: immediate return to IDLE with all cells EMPTY.
- Widths: all address arithmetic is modulo 64; there are no out-of-range cells.

Optional Feature:
- Macro SHIP_HIDE_EN, which adds input hide_ships (1 bit).
- With SHIP_HIDE_EN defined: when hide_ships=1 at stage 2, SHIP renders as EMPTY. HIT and MISS render normally. This is used for the opponent's board.
- Without it: no hide_ships port, and SHIP always renders as defined above.

Test Plan:
- Reset, then read: after rst, figure_xy=0..63 with any figure_line -> figure_pixels=64'h0 for every cell, 2 clk after each figure_xy.
- Latency check: write cell 9=SHIP; figure_xy=9 at edge N, figure_line=10 at edge N+1 -> at N+2 figure_pixels=64'h0055_5555_5555_5500 (pixels 4..27 = 01). With figure_line=2 -> 64'h0.
- HIT and MISS sprites:
  - Cell 20=HIT, line 10 -> pixels 10 and 21 = 11, pixels 4..27 otherwise 01.
  - Cell 21=MISS, line 15 -> pixels 12..19 = 10, rest 00 (64'h0000_00AA_AA00_0000).
- Same-cycle write/read: write cell 5=MISS on the same edge figure_xy=5 is sampled -> the first response is EMPTY (all 0); the next request returns the MISS line.
- Clear sweep: fill all cells with SHIP, pulse clear_req, and present a write during the sweep -> busy high exactly 64 cycles, ready low throughout, the write is not accepted, and all reads afterwards return 0. A second clear_req mid-sweep does not extend busy.
- Reset mid-sweep, plus SHIP_HIDE_EN:
  - Assert rst at sweep cycle 30 -> busy=0 immediately and the board is all EMPTY.
  - With SHIP_HIDE_EN and hide_ships=1: a SHIP cell reads 0 and a HIT cell still shows its diagonal.
